// File: rtl/hazard_fwd_unit.sv
// Load-use stall / EX operand-forwarding unit over EX/MEM/WB shadow stages; HAZARD_STALL_CNT_EN adds stall_cnt.
// Latency: fwdA/fwdB/stall are combinational from registered shadows (zero cycles); ex_bubble is registered.
// Backpressure: stall holds PC and IF/ID for one cycle on load-use; flush_i kills ID and overrides stall.
module hazard_fwd_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       id_wen,
    input  logic       id_memRead,
    input  logic       id_memWrite,
    input  logic       id_regDst,
    input  logic       id_jal,
    input  logic       id_alusrc,
    input  logic       flush_i,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic       stall,
    output logic       ex_bubble
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef struct packed {
        logic       vld;
        logic [4:0] dst;
        logic       wen;
        logic       mem_read;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
    } stage_t;

    stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic   ex_bubble_q, ex_bubble_d;
    logic   [4:0] id_dst;
    logic   id_uses_rt;
    logic   load_use;
    logic   kill_id;

    function automatic logic is_src(input stage_t s);
        return s.vld & s.wen & (s.dst != 5'd0);
    endfunction

    always_comb begin
        id_dst     = id_jal ? 5'd31 : (id_regDst ? id_rd : id_rt);
        id_uses_rt = !id_alusrc | id_memWrite;
        load_use   = id_valid & ex_q.vld & ex_q.mem_read & ex_q.wen & (ex_q.dst != 5'd0)
                   & ((ex_q.dst == id_rs) | ((ex_q.dst == id_rt) & id_uses_rt));
        // Outputs are held quiet while reset is asserted so stale shadows cannot leak out.
        stall      = load_use & !flush_i & rst_n;
        kill_id    = stall | flush_i | !id_valid;

        ex_d.vld      = !kill_id;
        ex_d.dst      = id_dst;
        ex_d.wen      = id_wen;
        ex_d.mem_read = id_memRead;
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.uses_rt  = id_uses_rt;
        mem_d         = ex_q;
        wb_d          = mem_q;
        ex_bubble_d   = kill_id;

        fwdA = 2'b00;
        fwdB = 2'b00;
        if (rst_n && ex_q.vld) begin
            if (is_src(mem_q) && (mem_q.dst == ex_q.rs))
                fwdA = 2'b10;
            else if (is_src(wb_q) && (wb_q.dst == ex_q.rs))
                fwdA = 2'b01;
            if (ex_q.uses_rt) begin
                if (is_src(mem_q) && (mem_q.dst == ex_q.rt))
                    fwdB = 2'b10;
                else if (is_src(wb_q) && (wb_q.dst == ex_q.rt))
                    fwdB = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            ex_bubble_q <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            ex_bubble_q <= ex_bubble_d;
        end
    end

    assign ex_bubble = ex_bubble_q;

    // WB is the last stage; its source-side fields have no further consumer.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.mem_read, wb_q.rs, wb_q.rt, wb_q.uses_rt};

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios plus random instruction streams
// compared against an age-ordered pipeline history model.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_wen, id_memRead, id_memWrite, id_regDst, id_jal, id_alusrc;
    logic       flush_i;
    logic [1:0] fwdA, fwdB;
    logic       stall, ex_bubble;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          obs_cnt;
`endif

    always #5 clk = ~clk;

    hazard_fwd_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_wen(id_wen), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_regDst(id_regDst), .id_jal(id_jal), .id_alusrc(id_alusrc),
        .flush_i(flush_i), .fwdA(fwdA), .fwdB(fwdB),
        .stall(stall), .ex_bubble(ex_bubble)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; index is age in cycles past ID.
    typedef struct {
        bit vld;
        int dst;
        bit wen;
        bit mr;
        int rs;
        int rt;
        bit urt;
    } ent_t;

    ent_t pipe[3];
    bit   m_bubble = 0;
    int   m_cnt = 0;
    bit   last_stall = 0;
    int   obs_fwdA, obs_fwdB, obs_stall, obs_bub;

    function automatic int exp_fwd(input int r, input bit needed);
        if (!rst_n || !pipe[0].vld || !needed) return 0;
        for (int a = 1; a <= 2; a++)
            if (pipe[a].vld && pipe[a].wen && pipe[a].dst != 0 && pipe[a].dst == r)
                return (a == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit urt;
        int d;
        urt = !id_alusrc || id_memWrite;
        d   = pipe[0].dst;
        if (!rst_n || flush_i || !id_valid) return 0;
        if (!(pipe[0].vld && pipe[0].mr && pipe[0].wen && d != 0)) return 0;
        return (d == int'(id_rs)) || (d == int'(id_rt) && urt);
    endfunction

    // Called at posedge+1: checks the settled outputs, advances the model, waits one edge.
    task automatic cycle();
        bit es;
        es = exp_stall();
        #3;
        obs_fwdA  = int'(fwdA);
        obs_fwdB  = int'(fwdB);
        obs_stall = int'(stall);
        obs_bub   = int'(ex_bubble);
        chk("fwdA", fwdA, exp_fwd(pipe[0].rs, 1'b1));
        chk("fwdB", fwdB, exp_fwd(pipe[0].rt, pipe[0].urt));
        chk("stall", stall, es);
        chk("ex_bubble", ex_bubble, m_bubble);
`ifdef HAZARD_STALL_CNT_EN
        obs_cnt = int'(stall_cnt);
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
        last_stall = es;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i].vld = 0;
            m_bubble = 0;
            m_cnt    = 0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0].vld = id_valid && !es && !flush_i;
            pipe[0].dst = id_jal ? 31 : (id_regDst ? int'(id_rd) : int'(id_rt));
            pipe[0].wen = id_wen;
            pipe[0].mr  = id_memRead;
            pipe[0].rs  = id_rs;
            pipe[0].rt  = id_rt;
            pipe[0].urt = !id_alusrc || id_memWrite;
            m_bubble    = es || flush_i || !id_valid;
            if (es && m_cnt < 65535) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int rs, input int rt, input int rd, input bit wen,
                          input bit mr, input bit mw, input bit rdst, input bit jal,
                          input bit asrc, input bit fl);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
        id_wen = wen; id_memRead = mr; id_memWrite = mw;
        id_regDst = rdst; id_jal = jal; id_alusrc = asrc; flush_i = fl;
    endtask

    task automatic alu(input int d, input int s, input int t, input bit fl = 0);
        set_in(1, s, t, d, 1, 0, 0, 1, 0, 0, fl);
        cycle();
    endtask

    task automatic addi(input int t, input int s);
        set_in(1, s, t, 0, 1, 0, 0, 0, 0, 1, 0);
        cycle();
    endtask

    task automatic lw(input int t, input int s);
        set_in(1, s, t, 0, 1, 1, 0, 0, 0, 1, 0);
        cycle();
    endtask

    task automatic nop();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0, 0};
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        nop();
        chk("rst_stall", obs_stall, 0);
        chk("rst_bubble", obs_bub, 0);
        rst_n = 1'b1;

        // Back-to-back ALU dependency
        alu(3, 1, 2); alu(4, 3, 5); nop();
        chk("b2b_fwdA", obs_fwdA, 2);
        chk("b2b_stall", obs_stall, 0);

        // Distance-2 dependency
        alu(3, 1, 2); alu(10, 11, 12); alu(6, 3, 7); nop();
        chk("dist2_fwdA", obs_fwdA, 1);

        // Load-use: one stall cycle, bubble, then WB forward
        lw(8, 1); alu(9, 8, 1);
        chk("lu_stall", obs_stall, 1);
        alu(9, 8, 1);
        chk("lu_stall_end", obs_stall, 0);
        chk("lu_bubble", obs_bub, 1);
`ifdef HAZARD_STALL_CNT_EN
        chk("lu_cnt", obs_cnt, 1);
`endif
        nop();
        chk("lu_fwdA", obs_fwdA, 1);

        // Register zero never forwards or stalls
        alu(0, 1, 2); alu(4, 0, 5); nop();
        chk("r0_fwdA", obs_fwdA, 0);
        lw(0, 1); alu(9, 0, 1);
        chk("r0_stall", obs_stall, 0);
        nop();

        // Double match: MEM wins
        alu(3, 1, 2); addi(3, 1); alu(5, 3, 1); nop();
        chk("dbl_fwdA", obs_fwdA, 2);

        // Flush during load-use
        lw(8, 1); alu(9, 8, 1, 1);
        chk("fl_stall", obs_stall, 0);
        nop();
        chk("fl_bubble", obs_bub, 1);
        chk("fl_fwdA", obs_fwdA, 0);

        // Reset mid-stall discards in-flight state
        lw(8, 1);
        rst_n = 1'b0;
        alu(9, 8, 1);
        chk("rst_mid_stall", obs_stall, 0);
        rst_n = 1'b1;
        alu(9, 8, 1);
        chk("rst_post_stall", obs_stall, 0);
        chk("rst_post_bubble", obs_bub, 0);
        nop();
        chk("rst_post_fwdA", obs_fwdA, 0);

        // Random streams over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!last_stall) begin
                id_valid    = ($urandom_range(0, 7) != 0);
                id_rs       = 5'($urandom_range(0, 3));
                id_rt       = 5'($urandom_range(0, 3));
                id_rd       = 5'($urandom_range(0, 3));
                id_wen      = 1'($urandom);
                id_memRead  = 1'($urandom);
                id_memWrite = 1'($urandom);
                id_regDst   = 1'($urandom);
                id_jal      = ($urandom_range(0, 15) == 0);
                id_alusrc   = 1'($urandom);
            end
            flush_i = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
